// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_UPD = 2'd2
    } fetch_state_e;

    localparam int          FETCH_PC_WIDTH = 16;
    localparam logic [15:0] FETCH_RESET_PC = 16'h3000;

endpackage

// File: rtl/fetch_ctrl_perf_cnt.sv
// Free-running performance counters for the fetch stage: completed fetches
// and memory stall cycles. Both wrap at 2^32.
module fetch_ctrl_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic        instrmem_rd,
    input  logic        imem_ready,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (fetch_valid)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (instrmem_rd && !imem_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns pc, drives the imem read strobe, squashes fetches
// overtaken by a redirect. Perf counters exist only with FETCH_CTRL_PERF_CNT_EN.
//
// state    | meaning
// IDLE     | no request outstanding; branch may load pc directly
// REQ      | read strobe high, pc frozen until imem_ready
// WAIT_UPD | fetch done but pipeline has not yet allowed pc to advance
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH = FETCH_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_fetch,
    input  logic                enable_updatePC,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] taddr,
    input  logic                imem_ready,
    output logic                instrmem_rd,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] npc,
    output logic                fetch_valid,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt
);

    fetch_state_e        state;
    logic                squash;
    logic [PC_WIDTH-1:0] redir_pc;
    logic [PC_WIDTH-1:0] upd_pc;

    assign npc    = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign upd_pc = br_taken ? taddr : npc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instrmem_rd <= 1'b0;
            fetch_valid <= 1'b0;
            squash      <= 1'b0;
            redir_pc    <= '0;
        end else begin
            fetch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_updatePC && br_taken)
                        pc <= taddr;
                    if (enable_fetch) begin
                        state       <= REQ;
                        instrmem_rd <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        if (squash) begin
                            // the returned word belongs to the old path: drop it
                            pc          <= redir_pc;
                            squash      <= 1'b0;
                            state       <= enable_fetch ? REQ : IDLE;
                            instrmem_rd <= enable_fetch;
                        end else if (enable_updatePC) begin
                            pc          <= upd_pc;
                            fetch_valid <= 1'b1;
                            state       <= enable_fetch ? REQ : IDLE;
                            instrmem_rd <= enable_fetch;
                        end else begin
                            fetch_valid <= 1'b1;
                            state       <= WAIT_UPD;
                            instrmem_rd <= 1'b0;
                        end
                    end else if (enable_updatePC && br_taken) begin
                        redir_pc <= taddr;
                        squash   <= 1'b1;
                    end
                end
                WAIT_UPD: begin
                    if (enable_updatePC) begin
                        pc          <= upd_pc;
                        state       <= enable_fetch ? REQ : IDLE;
                        instrmem_rd <= enable_fetch;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instrmem_rd <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_CNT_EN
    fetch_ctrl_perf_cnt u_perf_cnt (
        .clock       (clock),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .instrmem_rd (instrmem_rd),
        .imem_ready  (imem_ready),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
    );
`else
    assign fetch_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl against a cycle-level
// behavioural model of the fetch rules.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_fetch = 1'b0;
    logic        enable_updatePC = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = 16'h0;
    logic        imem_ready = 1'b0;
    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] npc;
    logic        fetch_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FETCH_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .imem_ready      (imem_ready),
        .instrmem_rd     (instrmem_rd),
        .pc              (pc),
        .npc             (npc),
        .fetch_valid     (fetch_valid),
        .fetch_cnt       (fetch_cnt),
        .stall_cnt       (stall_cnt)
    );

    always #5 clock = ~clock;

    // model: busy = read outstanding, hold = fetched but pc not yet advanced
    logic [15:0] m_pc;
    logic [15:0] m_redir;
    bit          m_busy, m_hold, m_sq, m_fv;
    logic [31:0] m_fcnt, m_scnt;

    task automatic model_reset();
        m_pc = 16'h3000; m_redir = 16'h0;
        m_busy = 0; m_hold = 0; m_sq = 0; m_fv = 0;
        m_fcnt = 0; m_scnt = 0;
    endtask

    task automatic model_clock();
        bit          fv_n = 0;
        logic [15:0] seq = m_pc + 16'd1;
        if (m_fv) m_fcnt = m_fcnt + 32'd1;
        if (m_busy && !imem_ready) m_scnt = m_scnt + 32'd1;
        if (m_hold) begin
            if (enable_updatePC) begin
                m_pc = br_taken ? taddr : seq;
                m_hold = 0;
                m_busy = enable_fetch;
            end
        end else if (!m_busy) begin
            if (enable_updatePC && br_taken) m_pc = taddr;
            if (enable_fetch) m_busy = 1;
        end else if (imem_ready) begin
            if (m_sq) begin
                m_pc = m_redir; m_sq = 0; m_busy = enable_fetch;
            end else if (enable_updatePC) begin
                m_pc = br_taken ? taddr : seq; fv_n = 1; m_busy = enable_fetch;
            end else begin
                fv_n = 1; m_hold = 1; m_busy = 0;
            end
        end else if (enable_updatePC && br_taken) begin
            m_redir = taddr; m_sq = 1;
        end
        m_fv = fv_n;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_npc = m_pc + 16'd1;
        chk({tag, ":pc"}, {16'h0, pc}, {16'h0, m_pc});
        chk({tag, ":npc"}, {16'h0, npc}, {16'h0, exp_npc});
        chk({tag, ":rd"}, {31'h0, instrmem_rd}, {31'h0, m_busy});
        chk({tag, ":fv"}, {31'h0, fetch_valid}, {31'h0, m_fv});
        chk({tag, ":fcnt"}, fetch_cnt, PERF ? m_fcnt : 32'd0);
        chk({tag, ":scnt"}, stall_cnt, PERF ? m_scnt : 32'd0);
    endtask

    task automatic step(input string tag, input bit ef, input bit eu, input bit br,
                        input bit rdy, input logic [15:0] ta);
        enable_fetch = ef; enable_updatePC = eu; br_taken = br;
        imem_ready = rdy; taddr = ta;
        @(posedge clock);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        model_reset();
        check_all("reset");
        #2;
        reset = 1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("por");
        reset = 1;

        // zero-wait back-to-back fetch
        step("b2b0", 1, 1, 0, 1, 16'h0);
        chk("b2b_pc0", {16'h0, pc}, 32'h3000);
        step("b2b1", 1, 1, 0, 1, 16'h0);
        chk("b2b_pc1", {16'h0, pc}, 32'h3001);
        chk("b2b_fv1", {31'h0, fetch_valid}, 32'd1);
        step("b2b2", 1, 1, 0, 1, 16'h0);
        chk("b2b_pc2", {16'h0, pc}, 32'h3002);
        chk("b2b_rd2", {31'h0, instrmem_rd}, 32'd1);
        step("b2b3", 0, 1, 0, 1, 16'h0);
        step("b2b4", 0, 0, 0, 0, 16'h0);

        // three wait states
        do_reset();
        step("st0", 1, 1, 0, 0, 16'h0);
        step("st1", 1, 1, 0, 0, 16'h0);
        step("st2", 1, 1, 0, 0, 16'h0);
        step("st3", 0, 1, 0, 0, 16'h0);
        chk("st_hold", {16'h0, pc}, 32'h3000);
        step("st4", 0, 1, 0, 1, 16'h0);
        chk("st_pc", {16'h0, pc}, 32'h3001);
        step("st5", 0, 0, 0, 0, 16'h0);
        chk("st_scnt", stall_cnt, PERF ? 32'd3 : 32'd0);
        chk("st_fcnt", fetch_cnt, PERF ? 32'd1 : 32'd0);

        // redirect while a read is outstanding squashes it
        do_reset();
        step("sq0", 1, 1, 0, 0, 16'h0);
        step("sq1", 1, 1, 1, 0, 16'h4000);
        step("sq2", 1, 1, 0, 0, 16'h0);
        step("sq3", 1, 1, 0, 1, 16'h0);
        chk("sq_pc", {16'h0, pc}, 32'h4000);
        chk("sq_fv", {31'h0, fetch_valid}, 32'd0);
        step("sq4", 0, 1, 0, 1, 16'h0);
        chk("sq_next", {16'h0, pc}, 32'h4001);

        // completion without update permission parks in WAIT_UPD
        do_reset();
        step("wu0", 1, 1, 0, 0, 16'h0);
        step("wu1", 1, 0, 0, 1, 16'h0);
        chk("wu_rd", {31'h0, instrmem_rd}, 32'd0);
        chk("wu_pc", {16'h0, pc}, 32'h3000);
        step("wu2", 1, 1, 0, 0, 16'h0);
        chk("wu_pc2", {16'h0, pc}, 32'h3001);
        chk("wu_rd2", {31'h0, instrmem_rd}, 32'd1);
        step("wu3", 0, 1, 0, 1, 16'h0);

        // pc wrap
        do_reset();
        step("wr0", 0, 1, 1, 0, 16'hFFFF);
        step("wr1", 1, 0, 0, 0, 16'h0);
        step("wr2", 0, 1, 0, 1, 16'h0);
        chk("wr_pc", {16'h0, pc}, 32'h0000);
        chk("wr_npc", {16'h0, npc}, 32'h0001);

        // async reset with a pending redirect
        do_reset();
        step("ar0", 1, 1, 0, 0, 16'h0);
        step("ar1", 1, 1, 1, 0, 16'h5555);
        #2;
        reset = 0;
        #1;
        model_reset();
        chk("ar_pc", {16'h0, pc}, 32'h3000);
        chk("ar_rd", {31'h0, instrmem_rd}, 32'd0);
        check_all("ar");
        #2;
        reset = 1;
        step("ar2", 1, 1, 0, 0, 16'h0);
        step("ar3", 0, 1, 0, 1, 16'h0);
        chk("ar_fv", {31'h0, fetch_valid}, 32'd1);
        chk("ar_pc2", {16'h0, pc}, 32'h3001);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step("rnd", ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                 ($urandom % 2) == 1, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction fetch stage. Owns the program counter, drives the instruction-memory read strobe and `pc`/`npc` toward memory and decode, and reconciles fetch/update enables from the pipeline controller with branch redirects and a variable-latency memory handshake. Sits between the pipeline control unit and the fetch_out bus.

## Interface
Parameters:
- PC_WIDTH, 16, width of pc/npc/taddr
- RESET_PC, 16'h3000, pc value loaded on reset

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable_fetch  input  1  pipeline permits issuing fetches
- enable_updatePC  input  1  pipeline permits pc to advance
- br_taken  input  1  redirect request, qualified by enable_updatePC
- taddr  input  PC_WIDTH  redirect target
- imem_ready  input  1  memory completes the current read this cycle
- instrmem_rd  output  1  read strobe, held until imem_ready
- pc  output  PC_WIDTH  address of current fetch
- npc  output  PC_WIDTH  pc + 1
- fetch_valid  output  1  one-cycle pulse: completed, non-squashed fetch
- fetch_cnt  output  32  completed fetches (perf)
- stall_cnt  output  32  cycles instrmem_rd high without imem_ready (perf)

## Operation
- States: IDLE, REQ, WAIT_UPD.
- Reset: state IDLE, pc=RESET_PC, instrmem_rd=0, fetch_valid=0, squash flag=0, counters=0.
- IDLE: instrmem_rd=0; enable_fetch=1 -> REQ. enable_updatePC & br_taken in IDLE loads pc<=taddr directly.
- REQ: instrmem_rd=1, pc frozen. Request never abandoned; enable_fetch dropping mid-REQ has no effect until imem_ready.
- Redirect during REQ (enable_updatePC & br_taken, no imem_ready same cycle): latch taddr into redirect register, set squash flag; last such redirect wins.
- Completion (REQ & imem_ready):
  - squash set: pc<=redirect register, squash cleared, fetch_valid stays 0.
  - else enable_updatePC=1: pc <= br_taken ? taddr : npc; fetch_valid<=1.
  - else: pc held, fetch_valid<=1, -> WAIT_UPD.
  - next state REQ if enable_fetch else IDLE (except WAIT_UPD case).
- WAIT_UPD: instrmem_rd=0; on enable_updatePC, pc <= br_taken ? taddr : npc, then REQ if enable_fetch else IDLE.
- npc = pc + 1 mod 2^PC_WIDTH; 16'hFFFF -> 16'h0000, no flag.
- Redirect coincident with imem_ready (no squash pending): treated as normal completion with br_taken, fetch_valid=1.

## Timing
- instrmem_rd, pc, fetch_valid registered; npc combinational from pc.
- IDLE with enable_fetch at edge N -> instrmem_rd=1 after edge N.
- imem_ready at edge M -> new pc and fetch_valid visible after edge M; back-to-back fetch keeps instrmem_rd high continuously, one fetch per cycle at zero wait.
- fetch_valid high exactly one cycle per non-squashed completion.
- reset asserted mid-REQ: all outputs to reset values immediately (asynchronous); pending redirect discarded.

## Configuration
- FETCH_CTRL_PERF_CNT_EN defined: fetch_cnt increments on every fetch_valid, stall_cnt on every cycle instrmem_rd=1 & imem_ready=0; both wrap at 2^32, cleared by reset.
- Undefined: counter logic absent, fetch_cnt and stall_cnt tied to 0; ports remain.

## Structure
- fetch_ctrl_pkg: state enum (IDLE, REQ, WAIT_UPD), FETCH_PC_WIDTH=16, FETCH_RESET_PC=16'h3000.
- One sub-module: fetch_ctrl_perf_cnt (two 32-bit counters), instantiated only under FETCH_CTRL_PERF_CNT_EN.

## Test plan
- Reset then enable_fetch=1, enable_updatePC=1, imem_ready=1 constant -> pc 3000,3001,3002 on consecutive cycles, fetch_valid continuous, instrmem_rd continuous.
- imem_ready low 3 cycles in REQ -> pc holds 3000, instrmem_rd high 4 cycles, stall_cnt=3, single fetch_valid pulse.
- br_taken=1, taddr=4000 two cycles before imem_ready -> fetch_valid stays 0 on completion, next pc=4000, no 3001 fetch issued.
- enable_updatePC=0 at completion -> WAIT_UPD, instrmem_rd=0, pc 3000 held; enable_updatePC=1 next cycle -> pc=3001, REQ.
- pc=FFFF completion with enable_updatePC=1 -> pc=0000, npc=0001.
- reset driven low mid-REQ with pending redirect -> pc=3000, instrmem_rd=0, after release no squash behaviour on first fetch.
